// File: rtl/oven_pkg.sv
// ============================================================================
// Module      : oven_pkg
// Description : Shared state encodings, mode codes and helpers for the
//               toaster-oven bake-cycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package oven_pkg;

    typedef logic [1:0] oven_state_t;

    localparam oven_state_t IDLE    = 2'd0;
    localparam oven_state_t PREHEAT = 2'd1;
    localparam oven_state_t BAKE    = 2'd2;
    localparam oven_state_t DONE    = 2'd3;

    localparam logic [3:0] MODE_COLD = 4'd0;
    localparam logic [3:0] MODE_200  = 4'd2;
    localparam logic [3:0] MODE_300  = 4'd3;
    localparam logic [3:0] MODE_400  = 4'd4;

    localparam logic [8:0] TEMP_MAX   = 9'd400;
    localparam logic [2:0] BEEP_TICKS = 3'd6;

    function automatic logic sel_valid(input logic [3:0] sel);
        return (sel == 4'd2) || (sel == 4'd3) || (sel == 4'd4);
    endfunction

    function automatic logic [8:0] target_of(input logic [3:0] sel);
        case (sel)
            4'd2:    return 9'd200;
            4'd3:    return 9'd300;
            default: return TEMP_MAX;
        endcase
    endfunction

    function automatic logic [3:0] mode_of(input logic [8:0] t);
        if (t >= 9'd400)      return MODE_400;
        else if (t >= 9'd300) return MODE_300;
        else if (t >= 9'd200) return MODE_200;
        else                  return MODE_COLD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/oven_cycle_ctrl_if.sv
// ============================================================================
// Module      : oven_cycle_ctrl_if
// Description : User-input / display-output bundle of the bake controller.
//               The beep signal exists only with OVEN_DONE_BEEP_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface oven_cycle_ctrl_if;
    logic       start;
    logic       cancel;
    logic [3:0] temp_sel;
    logic [7:0] bake_time;
    logic [3:0] mode;
    logic       done;
    logic       heater_on;
    logic       busy;
    logic [8:0] cur_temp;
    logic [7:0] time_left;
`ifdef OVEN_DONE_BEEP_EN
    logic       beep;
`endif

    modport master (
        output start, cancel, temp_sel, bake_time,
        input  mode, done, heater_on, busy, cur_temp, time_left
`ifdef OVEN_DONE_BEEP_EN
        , input beep
`endif
    );

    modport slave (
        input  start, cancel, temp_sel, bake_time,
        output mode, done, heater_on, busy, cur_temp, time_left
`ifdef OVEN_DONE_BEEP_EN
        , output beep
`endif
    );
endinterface

`default_nettype wire

// File: rtl/oven_tick_gen.sv
// ============================================================================
// Module      : oven_tick_gen
// Description : Free-running 0..TICK_DIV-1 divider; tick is high for the
//               single cycle the count sits at TICK_DIV-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oven_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

`default_nettype wire

// File: rtl/oven_cycle_ctrl.sv
// ============================================================================
// Module      : oven_cycle_ctrl
// Description : Toaster-oven bake sequencer: preheat ramp, timed bake,
//               done/cool-down, with a modelled cabinet temperature.
//               Optional macro OVEN_DONE_BEEP_EN adds a done beeper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oven_cycle_ctrl
    import oven_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int AMBIENT   = 70,
    parameter int RAMP_STEP = 25
) (
    input  logic             clk,
    input  logic             reset,
    oven_cycle_ctrl_if.slave bus
);
    localparam logic [9:0] AMB10  = 10'(AMBIENT);
    localparam logic [9:0] STEP10 = 10'(RAMP_STEP);

    logic        w_tick;
    logic        w_start_edge;
    logic        w_start_ok;
    logic [9:0]  w_up_sum;
    logic [9:0]  w_down_sum;
    logic [8:0]  w_heat_temp;
    logic [8:0]  w_cool_temp;

    oven_state_t state_q, state_d;
    logic        start_q;
    logic [8:0]  target_q, target_d;
    logic [8:0]  temp_q, temp_d;
    logic [7:0]  time_q, time_d;
    logic [3:0]  mode_q;
    logic        done_q, heater_q, busy_q;

    oven_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // Heating saturates at the target, which also snaps a warm restart down.
    always_comb begin
        w_start_edge = bus.start & ~start_q;
        w_start_ok   = w_start_edge & sel_valid(bus.temp_sel);
        w_up_sum     = {1'b0, temp_q} + STEP10;
        w_down_sum   = {1'b0, temp_q} - STEP10;
        w_heat_temp  = (w_up_sum >= {1'b0, target_q}) ? target_q : w_up_sum[8:0];
        w_cool_temp  = ({1'b0, temp_q} >= AMB10 + STEP10) ? w_down_sum[8:0] : AMB10[8:0];
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        temp_d   = temp_q;
        time_d   = time_q;
        if (bus.cancel) begin
            state_d = IDLE;
            time_d  = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_tick) temp_d = w_cool_temp;
                    if (w_start_ok) begin
                        state_d  = PREHEAT;
                        target_d = target_of(bus.temp_sel);
                        time_d   = bus.bake_time;
                    end
                end
                PREHEAT: begin
                    if (w_tick) temp_d = w_heat_temp;
                    if (temp_q == target_q) state_d = (time_q != 8'd0) ? BAKE : DONE;
                end
                BAKE: begin
                    temp_d = target_q;
                    if (w_tick && time_q != 8'd0) begin
                        time_d = time_q - 8'd1;
                        if (time_q == 8'd1) state_d = DONE;
                    end
                end
                DONE: begin
                    if (w_tick) temp_d = w_cool_temp;
                    if (w_start_ok) begin
                        state_d  = PREHEAT;
                        target_d = target_of(bus.temp_sel);
                        time_d   = bus.bake_time;
                    end else if (temp_q == AMB10[8:0]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            target_q <= AMB10[8:0];
            temp_q   <= AMB10[8:0];
            time_q   <= 8'd0;
            mode_q   <= MODE_COLD;
            done_q   <= 1'b0;
            heater_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= bus.start;
            target_q <= target_d;
            temp_q   <= temp_d;
            time_q   <= time_d;
            mode_q   <= mode_of(temp_d);
            done_q   <= (state_d == DONE);
            heater_q <= (state_d == PREHEAT) || (state_d == BAKE);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign bus.mode      = mode_q;
    assign bus.done      = done_q;
    assign bus.heater_on = heater_q;
    assign bus.busy      = busy_q;
    assign bus.cur_temp  = temp_q;
    assign bus.time_left = time_q;

`ifdef OVEN_DONE_BEEP_EN
    logic       beep_q, beep_d;
    logic [2:0] beep_cnt_q, beep_cnt_d;

    // The tick that enters DONE does not count as a beep tick.
    always_comb begin
        beep_d     = beep_q;
        beep_cnt_d = beep_cnt_q;
        if (state_d != DONE || state_q != DONE) begin
            beep_d     = 1'b0;
            beep_cnt_d = 3'd0;
        end else if (w_tick && beep_cnt_q < BEEP_TICKS) begin
            beep_d     = ~beep_q;
            beep_cnt_d = beep_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beep_q     <= 1'b0;
            beep_cnt_q <= 3'd0;
        end else begin
            beep_q     <= beep_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign bus.beep = beep_q;
`endif
endmodule

`default_nettype wire
